// File: rtl/xrs_mp.sv
`default_nettype none
// ============================================================================
// Module      : xrs_mp
// Description : Integer register bank, one lane-masked write port, two
//               registered read ports, write-first forwarding, x0 == 0 and a
//               post-reset clear sequencer.
// Revision    : 1.0
// ============================================================================
module xrs_mp #(
  parameter int DATA_W = 64,
  parameter int LANE_W = 16,
  parameter int ADDR_W = 5,
  localparam int LANES = DATA_W / LANE_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] wa_i,
  input  logic [DATA_W-1:0] wdat_i,
  input  logic [LANES-1:0]  wmask_i,
  input  logic [ADDR_W-1:0] ra1_i,
  input  logic [ADDR_W-1:0] ra2_i,
  output logic [DATA_W-1:0] rdat1_o,
  output logic [DATA_W-1:0] rdat2_o,
  output logic              busy_o
);

  localparam int                c_depth = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] c_first = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_last  = {ADDR_W{1'b1}};

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic              w_clr_en;
  logic              w_wr_en;
  logic              w_hit1;
  logic              w_hit2;
  logic [DATA_W-1:0] w_fwd1;
  logic [DATA_W-1:0] w_fwd2;
  logic [DATA_W-1:0] r_rdat1;
  logic [DATA_W-1:0] r_rdat2;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= ST_CLEAR;
      r_ptr   <= c_first;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Clear walks entries 1..last; entry 0 is never stored meaningfully.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_CLEAR: begin
        w_ptr_nxt = r_ptr + ADDR_W'(1);
        if (r_ptr == c_last) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_ptr_nxt   = c_first;
      end
    endcase
  end

  assign w_clr_en = (r_state == ST_CLEAR) && !reset_i;
  assign w_wr_en  = (r_state == ST_RUN) && !reset_i &&
                    (wa_i != '0) && (wmask_i != '0);
  assign w_hit1   = w_wr_en && (ra1_i == wa_i);
  assign w_hit2   = w_wr_en && (ra2_i == wa_i);

  // One storage column per lane keeps the mask a plain per-RAM write enable.
  for (genvar n = 0; n < LANES; n++) begin : g_lane
    logic [LANE_W-1:0] r_col [c_depth];

    always_ff @(posedge clk_i) begin
      if (w_clr_en) begin
        r_col[r_ptr] <= '0;
      end else if (w_wr_en && wmask_i[n]) begin
        r_col[wa_i] <= wdat_i[n*LANE_W +: LANE_W];
      end
    end

    assign w_fwd1[n*LANE_W +: LANE_W] = (w_hit1 && wmask_i[n]) ?
                                        wdat_i[n*LANE_W +: LANE_W] : r_col[ra1_i];
    assign w_fwd2[n*LANE_W +: LANE_W] = (w_hit2 && wmask_i[n]) ?
                                        wdat_i[n*LANE_W +: LANE_W] : r_col[ra2_i];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || (r_state == ST_CLEAR)) begin
      r_rdat1 <= '0;
      r_rdat2 <= '0;
    end else begin
      r_rdat1 <= (ra1_i == '0) ? '0 : w_fwd1;
      r_rdat2 <= (ra2_i == '0) ? '0 : w_fwd2;
    end
  end

  assign rdat1_o = r_rdat1;
  assign rdat2_o = r_rdat2;
  assign busy_o  = (r_state == ST_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_xrs_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_xrs_mp
// Description : Self-checking bench for xrs_mp with a behavioural register
//               bank model, directed scenarios and randomized traffic.
// Revision    : 1.0
// ============================================================================
module tb_xrs_mp;

  localparam int DW    = 64;
  localparam int LW    = 16;
  localparam int AW    = 5;
  localparam int NL    = DW / LW;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic [AW-1:0] wa_i = '0;
  logic [DW-1:0] wdat_i = '0;
  logic [NL-1:0] wmask_i = '0;
  logic [AW-1:0] ra1_i = '0;
  logic [AW-1:0] ra2_i = '0;
  logic [DW-1:0] rdat1_o;
  logic [DW-1:0] rdat2_o;
  logic          busy_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] m_mem [DEPTH];
  int            m_left = DEPTH - 1;
  logic [DW-1:0] e_r1 = '0;
  logic [DW-1:0] e_r2 = '0;

  xrs_mp #(.DATA_W(DW), .LANE_W(LW), .ADDR_W(AW)) u_dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .wa_i    (wa_i),
    .wdat_i  (wdat_i),
    .wmask_i (wmask_i),
    .ra1_i   (ra1_i),
    .ra2_i   (ra2_i),
    .rdat1_o (rdat1_o),
    .rdat2_o (rdat2_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [NL-1:0] mask);
    logic [DW-1:0] res = old;
    for (int n = 0; n < NL; n++)
      if (mask[n]) res[n*LW +: LW] = nw[n*LW +: LW];
    return res;
  endfunction

  // Reference: a reset wipes everything (observably), then DEPTH-1 busy edges.
  task automatic model_edge();
    logic wr;
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_left = DEPTH - 1;
      e_r1 = '0;
      e_r2 = '0;
    end else if (m_left > 0) begin
      m_left--;
      e_r1 = '0;
      e_r2 = '0;
    end else begin
      wr   = (wa_i != 0) && (wmask_i != 0);
      e_r1 = (ra1_i == 0) ? '0 : (wr && ra1_i == wa_i) ? merge(m_mem[ra1_i], wdat_i, wmask_i) : m_mem[ra1_i];
      e_r2 = (ra2_i == 0) ? '0 : (wr && ra2_i == wa_i) ? merge(m_mem[ra2_i], wdat_i, wmask_i) : m_mem[ra2_i];
      if (wr) m_mem[wa_i] = merge(m_mem[wa_i], wdat_i, wmask_i);
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    chk({tag, ".busy"}, {63'd0, busy_o}, {63'd0, (m_left > 0)});
    chk({tag, ".rd1"}, rdat1_o, e_r1);
    chk({tag, ".rd2"}, rdat2_o, e_r2);
  endtask

  task automatic cyc(input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [NL-1:0] m, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                     input string tag);
    reset_i = r;
    wa_i    = a;
    wdat_i  = d;
    wmask_i = m;
    ra1_i   = a1;
    ra2_i   = a2;
    step(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, '0, '0, '0, tag);
  endtask

  initial begin
    // Reset then clear, with a write attempt locked out on the first busy edge
    cyc(1'b1, '0, '0, '0, '0, '0, "rst");
    cyc(1'b1, '0, '0, '0, '0, '0, "rst");
    chk("rst_busy", {63'd0, busy_o}, 64'd1);
    cyc(1'b0, 5'd3, 64'h55, 4'hF, 5'd3, 5'd3, "lock");
    idle(DEPTH - 2, "clr");
    chk("clr_done", {63'd0, busy_o}, 64'd0);
    for (int i = 1; i < DEPTH; i++) cyc(1'b0, '0, '0, '0, AW'(i), AW'(DEPTH - i), "rd0");
    cyc(1'b0, '0, '0, '0, 5'd3, 5'd3, "x3");
    chk("x3_zero", rdat1_o, 64'd0);

    // Lane mask
    cyc(1'b0, 5'd7, 64'h1111_2222_3333_4444, 4'b1111, '0, '0, "lm1");
    cyc(1'b0, 5'd7, 64'hAAAA_BBBB_CCCC_DDDD, 4'b0101, '0, '0, "lm2");
    cyc(1'b0, '0, '0, '0, 5'd7, 5'd7, "lm3");
    chk("lane_mask", rdat1_o, 64'h1111_BBBB_3333_DDDD);

    // Write-first forwarding on both ports
    cyc(1'b0, 5'd9, 64'h0123_4567_89AB_CDEF, 4'b1111, '0, '0, "fw1");
    cyc(1'b0, 5'd9, 64'hFFFF_0000_FFFF_0000, 4'b1000, 5'd9, 5'd9, "fw2");
    chk("fwd1", rdat1_o, 64'hFFFF_4567_89AB_CDEF);
    chk("fwd2", rdat2_o, 64'hFFFF_4567_89AB_CDEF);

    // Zero register
    cyc(1'b0, 5'd0, 64'hDEAD_BEEF_DEAD_BEEF, 4'b1111, 5'd0, 5'd9, "z1");
    chk("x0_fwd", rdat1_o, 64'd0);
    cyc(1'b0, '0, '0, '0, 5'd9, 5'd0, "z2");
    chk("x0_rd", rdat2_o, 64'd0);

    // Independent ports and output hold
    cyc(1'b0, 5'd1, 64'h11, 4'b1111, '0, '0, "dp1");
    cyc(1'b0, 5'd2, 64'h22, 4'b1111, '0, '0, "dp2");
    cyc(1'b0, '0, '0, '0, 5'd1, 5'd2, "dp3");
    ra1_i = 5'd3;
    ra2_i = 5'd4;
    #3;
    chk("hold1", rdat1_o, 64'h11);
    chk("hold2", rdat2_o, 64'h22);

    // Write lost across reset
    cyc(1'b0, 5'd5, '1, 4'b1111, '0, '0, "x5w");
    cyc(1'b0, '0, '0, '0, 5'd5, 5'd5, "x5r");
    chk("x5_set", rdat1_o, '1);
    cyc(1'b1, '0, '0, '0, '0, '0, "rst2");
    idle(DEPTH - 1, "clr2");
    cyc(1'b0, '0, '0, '0, 5'd5, 5'd5, "x5c");
    chk("x5_clr", rdat2_o, 64'd0);

    // Reset landing at clear edge 10 restarts the full sequence
    cyc(1'b1, '0, '0, '0, '0, '0, "rst3");
    idle(9, "clr3a");
    cyc(1'b1, '0, '0, '0, '0, '0, "rst4");
    idle(DEPTH - 1, "clr3b");
    chk("restart_done", {63'd0, busy_o}, 64'd0);

    // Randomized traffic with collision-prone addresses and rare resets
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 399) == 0),
          AW'($urandom_range(0, 7)),
          {$urandom, $urandom},
          NL'($urandom_range(0, 15)),
          AW'($urandom_range(0, 7)),
          AW'($urandom_range(0, 7)),
          "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
